calc_sequencer: RTL

Control sequencer for the two-function (add/sub) calculator datapath. Consumes one-cycle enter pulses and the keypad valid flag, and drives the operand/result load strobes, the add/sub select and the display-source select. Adds operand-presence checks, a configurable ALU settle delay, overflow-to-error handling and an optional auto-timeout of the result display. Sits between the enter edge detector, the keypad input unit, the arithmetic unit and the display mux/out-unit, all on the slow control clock.

---
 rtl/calc_pkg.sv | 18 +
 rtl/calc_hold_timer.sv | 30 +++
 rtl/calc_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared state encoding for the calculator control sequencer and its
// display/debug consumers.
package calc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT_A = 3'd0,
    S_LOAD_A = 3'd1,
    S_WAIT_B = 3'd2,
    S_LOAD_B = 3'd3,
    S_EXEC   = 3'd4,
    S_CHECK  = 3'd5,
    S_SHOW   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

endpackage

// File: rtl/calc_hold_timer.sv
// Loadable down-counter with a zero flag; shared by the ALU settle delay and
// the result-display timeout. Counting stops at zero.
module calc_hold_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (enable && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/calc_sequencer.sv
// Control sequencer for the add/sub calculator: operand capture, ALU settle
// delay, overflow check and result/error display with optional timeout.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int AU_LAT    = 2,
  parameter int SHOW_HOLD = 0,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enter_pulse,
  input  logic               key_valid,
  input  logic               op_sub,
  input  logic               overflow_in,
  output logic               loadA,
  output logic               loadB,
  output logic               loadR,
  output logic               add_sub_control,
  output logic               load_out_unit,
  output logic               sel,
  output logic               busy,
  output logic               error,
  output logic               nokey,
  output logic [STATE_W-1:0] state_dbg
);

  localparam bit               HOLD_EN   = (SHOW_HOLD > 0);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(AU_LAT - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_EN ? SHOW_HOLD - 1 : 0);

  state_e           state, next_state;
  logic             tmr_load, tmr_enable, tmr_zero;
  logic [CNT_W-1:0] tmr_value;
  logic             load_a_d, load_b_d, load_r_d, load_out_d, nokey_d;

  calc_hold_timer #(.CNT_W(CNT_W)) u_hold_timer (
    .clk    (clk),
    .rst_n  (reset),
    .load   (tmr_load),
    .value  (tmr_value),
    .enable (tmr_enable),
    .zero   (tmr_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    tmr_enable = 1'b0;
    load_a_d   = 1'b0;
    load_b_d   = 1'b0;
    load_r_d   = 1'b0;
    load_out_d = 1'b0;
    nokey_d    = 1'b0;

    unique case (state)
      S_WAIT_A, S_WAIT_B: begin
        if (enter_pulse && key_valid) next_state = (state == S_WAIT_A) ? S_LOAD_A : S_LOAD_B;
        else if (enter_pulse)         nokey_d    = 1'b1;
      end
      S_LOAD_A: begin
        load_a_d   = 1'b1;
        next_state = S_WAIT_B;
      end
      S_LOAD_B: begin
        load_b_d   = 1'b1;
        tmr_load   = 1'b1;
        tmr_value  = SETTLE_LD;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        if (tmr_zero) begin
          load_r_d   = 1'b1;
          next_state = S_CHECK;
        end else begin
          tmr_enable = 1'b1;
        end
      end
      S_CHECK: begin
        load_out_d = 1'b1;
        tmr_load   = HOLD_EN;
        tmr_value  = HOLD_LD;
        next_state = overflow_in ? S_ERR : S_SHOW;
      end
      S_SHOW, S_ERR: begin
        // Enter and timeout expiry collapse into the same single return.
        if (enter_pulse || (HOLD_EN && tmr_zero)) next_state = S_WAIT_A;
        else                                      tmr_enable = HOLD_EN;
      end
      default: next_state = S_WAIT_A;
    endcase

    if (clear) begin
      next_state = S_WAIT_A;
      tmr_load   = 1'b1;
      tmr_value  = '0;
      tmr_enable = 1'b0;
      load_a_d   = 1'b0;
      load_b_d   = 1'b0;
      load_r_d   = 1'b0;
      load_out_d = 1'b0;
      nokey_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_WAIT_A;
      loadA           <= 1'b0;
      loadB           <= 1'b0;
      loadR           <= 1'b0;
      load_out_unit   <= 1'b0;
      nokey           <= 1'b0;
      sel             <= 1'b0;
      busy            <= 1'b0;
      error           <= 1'b0;
      add_sub_control <= 1'b0;
    end else begin
      state         <= next_state;
      loadA         <= load_a_d;
      loadB         <= load_b_d;
      loadR         <= load_r_d;
      load_out_unit <= load_out_d;
      nokey         <= nokey_d;
      sel           <= (next_state == S_SHOW) || (next_state == S_ERR);
      busy          <= (next_state == S_LOAD_B) || (next_state == S_EXEC) || (next_state == S_CHECK);
      error         <= (next_state == S_ERR);
      if (clear)                 add_sub_control <= 1'b0;
      else if (state == S_LOAD_B) add_sub_control <= op_sub;
    end
  end

  assign state_dbg = state;

endmodule
